// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: issue stage between fetch and execute.
// Buffers fetched {instr, pc} pairs in a DEPTH-entry FIFO and decodes the head
// entry combinationally. The head is offered to execute over out_valid/out_ready.
// Multiply/divide heads are held until the shared multdiv unit reports md_done.
// flush squashes all in-flight state; reset has the same effect.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   flush               taken-branch squash (empties FIFO, FSM back to RUN)
//   in_valid/in_ready   fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready execute handshake; out_instr, out_pc head payload
//   out_opcode/rd/rs/rt decoded register/opcode fields of the head
//   out_imm             head immediate (sign-extended from bit 16)
//   md_start, md_done   one-cycle start pulse / completion from multdiv
//
// Optional feature: define DECODE_TARGET_EN to zero-extend the 27-bit jump
// target into out_imm for j, jal, setx and bex.
module decode_issue_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [4:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [31:0] out_imm,
  output logic        md_start,
  input  logic        md_done
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MD_START = 2'd1;
  localparam logic [1:0] S_MD_WAIT  = 2'd2;
  localparam logic [1:0] S_MD_ISSUE = 2'd3;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic          push;
  logic          pop;
  logic          not_empty;
  logic          head_md;
  logic [31:0]   head;
  logic [31:0]   sext_imm;

  // FIFO occupancy and handshakes; flush blocks both push and pop
  assign not_empty = (count != '0);
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Storage is not reset; only pointers and count define what is valid
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head decode
  assign head       = instr_mem[rd_ptr];
  assign out_instr  = head;
  assign out_pc     = pc_mem[rd_ptr];
  assign out_opcode = head[31:27];
  assign out_rd     = head[26:22];
  assign out_rs     = head[21:17];
  assign out_rt     = head[16:12];
  assign sext_imm   = {{15{head[16]}}, head[16:0]};

  // ALU-class opcode 0 with func 00110 (mul) or 00111 (div)
  assign head_md = (head[31:27] == 5'b00000) && (head[6:3] == 4'b0011);

`ifdef DECODE_TARGET_EN
  // Jump-style opcodes carry a 27-bit target instead of an immediate
  always_comb begin
    out_imm = sext_imm;
    if (head[31:27] == 5'b00001 || head[31:27] == 5'b00011 ||
        head[31:27] == 5'b10101 || head[31:27] == 5'b10110) begin
      out_imm = {5'b00000, head[26:0]};
    end
  end
`else
  assign out_imm = sext_imm;
`endif

  // Issue FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  // Issue FSM next state and outputs
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    md_start  = 1'b0;
    case (state)
      S_RUN: begin
        out_valid = not_empty & ~head_md;
        if (not_empty && head_md) state_nxt = S_MD_START;
      end
      S_MD_START: begin
        md_start  = 1'b1;
        state_nxt = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        if (md_done) state_nxt = S_MD_ISSUE;
      end
      S_MD_ISSUE: begin
        // Only a flush can empty the FIFO here, and flush also leaves this state
        out_valid = not_empty;
        if (out_ready) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
    if (flush) state_nxt = S_RUN;
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [4:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [31:0] out_imm;
  logic        md_start;
  logic        md_done;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  int   mcount = 0;

  decode_issue_ctrl #(.DEPTH(DEPTH)) dut (
    .clock     (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_opcode(out_opcode),
    .out_rd    (out_rd),
    .out_rs    (out_rs),
    .out_rt    (out_rt),
    .out_imm   (out_imm),
    .md_start  (md_start),
    .md_done   (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    logic [31:0] r;
    r = {{15{i[16]}}, i[16:0]};
`ifdef DECODE_TARGET_EN
    if (i[31:27] == 5'b00001 || i[31:27] == 5'b00011 ||
        i[31:27] == 5'b10101 || i[31:27] == 5'b10110)
      r = {5'b00000, i[26:0]};
`endif
    return r;
  endfunction

  // Scoreboard monitor: samples mid-cycle and models the coming rising edge
  always @(negedge clk) begin
    ent_t e;
    logic pushed;
    logic fired;
    if (!reset) begin
      checks++;
      if (in_ready !== (mcount < DEPTH)) begin
        errors++;
        $display("FAIL in_ready: got %b expected %b (model count %0d)", in_ready, (mcount < DEPTH), mcount);
      end
    end
    pushed = in_valid && (mcount < DEPTH) && !flush && !reset;
    fired  = (out_valid === 1'b1) && out_ready && !flush && !reset;
    if (reset || flush) begin
      q.delete();
      mcount = 0;
    end else begin
      if (fired) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_issue: issued %h pc %h with empty scoreboard", out_instr, out_pc);
        end else begin
          e = q.pop_front();
          if (out_instr !== e.instr || out_pc !== e.pc) begin
            errors++;
            $display("FAIL issue_order: got %h/%h expected %h/%h", out_instr, out_pc, e.instr, e.pc);
          end
          checks++;
          if (out_imm !== exp_imm(e.instr) || out_rd !== e.instr[26:22] ||
              out_opcode !== e.instr[31:27] || out_rs !== e.instr[21:17] || out_rt !== e.instr[16:12]) begin
            errors++;
            $display("FAIL issue_decode: imm %h rd %0d op %0d, expected imm %h rd %0d op %0d",
                     out_imm, out_rd, out_opcode, exp_imm(e.instr), e.instr[26:22], e.instr[31:27]);
          end
        end
      end
      if (pushed) q.push_back('{instr: in_instr, pc: in_pc});
      mcount = mcount + (pushed ? 1 : 0) - (fired ? 1 : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || md_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: in_ready %b out_valid %b md_start %b expected 1 0 0", in_ready, out_valid, md_start);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || md_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready %b out_valid %b md_start %b expected 1 0 0", in_ready, out_valid, md_start);
    end
  endtask

  task automatic test_imm();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2841FFFF; in_pc = 32'h0000_0100;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_rd !== 5'd1 || out_opcode !== 5'b00101) begin
      errors++;
      $display("FAIL imm_neg: valid %b imm %h rd %0d op %0d expected 1 ffffffff 1 5", out_valid, out_imm, out_rd, out_opcode);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2840FFFF; in_pc = 32'h0000_0104;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL imm_pos: valid %b imm %h expected 1 0000ffff", out_valid, out_imm);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL imm_empty: out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2881_0001; in_pc = 32'h0000_0200;
    cyc();
    in_instr = 32'h28C2_0002; in_pc = 32'h0000_0204;
    cyc();
    in_instr = 32'h2903_0003; in_pc = 32'h0000_0208;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h2881_0001) begin
      errors++;
      $display("FAIL bp_full: in_ready %b out_valid %b head %h expected 0 1 28810001", in_ready, out_valid, out_instr);
    end
    cyc();
    cyc();
    checks++;
    if (in_ready !== 1'b0 || out_instr !== 32'h2881_0001 || out_pc !== 32'h0000_0200) begin
      errors++;
      $display("FAIL bp_hold: in_ready %b head %h pc %h expected 0 28810001 00000200", in_ready, out_instr, out_pc);
    end
    out_ready = 1'b1;
    cyc();
    checks++;
    if (in_ready !== 1'b1 || out_instr !== 32'h28C2_0002) begin
      errors++;
      $display("FAIL bp_release: in_ready %b head %h expected 1 28c20002", in_ready, out_instr);
    end
    cyc();
    in_valid = 1'b0;
    wait_empty(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: %0d entries left expected 0", q.size());
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid %b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_multdiv();
    int pulses;
    int bad_valid;
    pulses = 0;
    bad_valid = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00C22018; in_pc = 32'h0000_0300;
    cyc();
    in_valid = 1'b0;
    if (out_valid !== 1'b0) bad_valid++;
    if (md_start === 1'b1) pulses++;
    cyc();
    checks++;
    if (md_start !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL md_start_cycle: md_start %b out_valid %b expected 1 0", md_start, out_valid);
    end
    if (md_start === 1'b1) pulses++;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (out_valid !== 1'b0) bad_valid++;
      if (md_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL md_pulses: got %0d expected 1", pulses);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL md_hold: out_valid high %0d cycles expected 0", bad_valid);
    end
    md_done = 1'b1;
    cyc();
    md_done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd3 || md_start !== 1'b0) begin
      errors++;
      $display("FAIL md_issue: out_valid %b rd %0d md_start %b expected 1 3 0", out_valid, out_rd, md_start);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL md_after: out_valid %b pending %0d expected 0 0", out_valid, q.size());
    end
  endtask

  task automatic test_flush_md();
    int bad;
    bad = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00C2201C; in_pc = 32'h0000_0400;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++;
    if (md_start !== 1'b1) begin
      errors++;
      $display("FAIL fl_start_pre: md_start %b expected 1", md_start);
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    checks++;
    if (md_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fl_start: md_start %b out_valid %b in_ready %b expected 0 0 1", md_start, out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h00C22018; in_pc = 32'h0000_0410;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    md_done = 1'b1;
    cyc();
    md_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0 || md_start !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fl_wait: %0d bad cycles in_ready %b expected 0 1", bad, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h2841FFFF; in_pc = 32'h0000_0420;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0420) begin
      errors++;
      $display("FAIL fl_next: out_valid %b pc %h expected 1 00000420", out_valid, out_pc);
    end
    wait_empty(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL fl_drain: %0d entries left expected 0", q.size());
    end
  endtask

  task automatic test_flush_push();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2881_0011; in_pc = 32'h0000_0500;
    cyc();
    in_instr = 32'h2881_0022; in_pc = 32'h0000_0504;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fp_empty: out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h2881_0033; in_pc = 32'h0000_0508;
    cyc();
    in_instr = 32'h2881_0044; in_pc = 32'h0000_050C;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_instr !== 32'h2881_0033) begin
      errors++;
      $display("FAIL fp_count: in_ready %b head %h expected 0 28810033", in_ready, out_instr);
    end
    out_ready = 1'b1;
    wait_empty(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL fp_drain: %0d entries left expected 0", q.size());
    end
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_jump();
    logic [31:0] exp;
`ifdef DECODE_TARGET_EN
    exp = 32'h00010000;
`else
    exp = 32'hFFFF0000;
`endif
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h08010000; in_pc = 32'h0000_0600;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_opcode !== 5'b00001 || out_imm !== exp) begin
      errors++;
      $display("FAIL jump_imm: valid %b op %0d imm %h expected 1 1 %h", out_valid, out_opcode, out_imm, exp);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = {5'b00101, 27'($urandom)};
      in_pc = 32'h0000_0700 + 32'(i * 4);
      cyc();
      if (out_valid !== 1'b1) gaps++;
    end
    in_valid = 1'b0;
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL b2b_throughput: %0d idle cycles expected 0", gaps);
    end
    wait_empty(10);
    cyc();
    checks++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: pending %0d out_valid %b expected 0 0", q.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    out_ready = 1'b0;
    md_done = 1'b0;
    test_reset();
    test_imm();
    test_backpressure();
    test_multdiv();
    test_flush_md();
    test_flush_push();
    test_jump();
    test_back_to_back();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Issue controller between fetch and execute in the processor pipeline. Buffers fetched instructions in a small FIFO and decodes the head entry's fields, including the 17-bit sign-extended immediate. Presents the head to execute over a valid/ready handshake. Holds back multiply/divide instructions until the shared multdiv unit signals completion, and clears all in-flight state on a branch flush.

## Interface
- DEPTH, 2: FIFO entries; power of two, 2..8.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears FIFO and FSM.
- flush  in  1  taken-branch squash; empties FIFO and returns FSM to RUN.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  FIFO can accept; equals count < DEPTH.
- in_instr  in  32  fetched instruction.
- in_pc  in  32  PC of fetched instruction.
- out_valid  out  1  head instruction issuable.
- out_ready  in  1  execute accepts head.
- out_instr, out_pc  out  32  head instruction and PC.
- out_opcode  out  5  head[31:27].
- out_rd, out_rs, out_rt  out  5  head[26:22], head[21:17], head[16:12].
- out_imm  out  32  head[16:0] sign-extended from bit 16.
- md_start  out  1  one-cycle start pulse to multdiv.
- md_done  in  1  multdiv result ready.

## Operation
- Push: in_valid & in_ready & !flush writes {instr, pc} at the write pointer. Pointers wrap modulo DEPTH.
- Pop: out_valid & out_ready & !flush advances the read pointer.
- Push and pop in the same cycle leave count unchanged. When full, in_ready=0, so no push occurs.
- Decode outputs are combinational from the head entry. They hold the last head value when empty; execute must ignore them while out_valid=0.
- Multdiv detect: opcode 00000 and head[6:2] equal to 00110 (mul) or 00111 (div).
- FSM states:
  - RUN: out_valid = (count>0) & !multdiv. If the head is multdiv, go to MD_START.
  - MD_START: out_valid=0, md_start=1. Always go to MD_WAIT next cycle.
  - MD_WAIT: out_valid=0. On md_done, go to MD_ISSUE. md_done is ignored in every other state.
  - MD_ISSUE: out_valid=1. Pop on out_ready, then go to RUN.
- flush takes priority over push, pop and md_done in the same cycle:
  - count and pointers go to 0; FSM goes to RUN.
  - An in-progress multdiv is abandoned. Any md_done arriving later is ignored.
- reset has the same effect as flush. Reset values: in_ready=1, out_valid=0, md_start=0, FSM=RUN, all pointers and count=0.

## Timing
- Push to out_valid latency: 1 cycle. An entry accepted at edge T is visible after T with out_valid high, provided the FIFO was empty and the head is not multdiv.
- Throughput: 1 instruction/cycle with out_ready held high.
- Multdiv sequence, with the head arriving at cycle N:
  - N: RUN detects multdiv.
  - N+1: MD_START, md_start=1.
  - N+2 onward: MD_WAIT.
  - md_done at cycle M gives out_valid=1 at M+1.
- md_start is never asserted for two consecutive cycles.
- A flush or reset during MD_START deasserts md_start in the following cycle.

## Configuration
- DECODE_TARGET_EN defined: for opcodes 00001 (j), 00011 (jal), 10101 (setx) and 10110 (bex), out_imm = {5'b0, head[26:0]} (zero-extended target). All other opcodes keep the sign-extended immediate.
- DECODE_TARGET_EN undefined: out_imm is always the sign-extended head[16:0].

## Test plan
- Immediate sign-extension: push 0x2841FFFF (addi $1,$0,-1) -> out_imm=0xFFFFFFFF, out_rd=1, out_opcode=00101. Push 0x2840FFFF -> out_imm=0x0000FFFF.
- Backpressure: DEPTH=2, out_ready=0, push 3 instructions -> in_ready=0 after 2 pushes, third is held. Raise out_ready -> issue order and PCs match push order, no loss or duplication.
- Multdiv: push 0x00C22018 (mul $3,$1,$2), md_done after 5 cycles in MD_WAIT -> exactly one md_start pulse, out_valid=0 until cycle after md_done, then issue with out_rd=3.
- Flush mid-multdiv: flush during MD_WAIT, then md_done -> FIFO empty, out_valid=0, no issue, md_done ignored. Next pushed instruction issues normally.
- Flush and push same cycle: in_valid=1, flush=1 -> count=0, pushed instruction discarded.
- Jump target: push 0x08010000 (j) -> out_imm=0xFFFF0000 without DECODE_TARGET_EN, 0x00010000 with it.
